// File: rtl/cpu_mmio_console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mmio_console_pkg
// Description : Shared definitions for the CPU MMIO console.
//               - Register offsets, taken from data_addr[3:2].
//               - STATUS bit positions.
//               - A helper that packs the STATUS word.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mmio_console_pkg;

    // Register offsets within the 16-byte window.
    typedef enum logic [1:0] {
        MMIO_TXDATA = 2'd0,
        MMIO_STATUS = 2'd1,
        MMIO_RXDATA = 2'd2,
        MMIO_CYCLE  = 2'd3
    } mmio_reg_e;

    // STATUS bit positions.
    localparam int STAT_TX_FULL      = 0;
    localparam int STAT_TX_EMPTY     = 1;
    localparam int STAT_RX_FULL      = 2;
    localparam int STAT_RX_OVERRUN   = 3;
    localparam int STAT_TX_OVERFLOW  = 4;
    localparam int STAT_TX_COUNT_LSB = 8;

    // Packs the STATUS word. All bits not listed in the map read as zero.
    function automatic logic [31:0] build_status(
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_full,
        input logic       rx_overrun,
        input logic       tx_overflow,
        input logic [7:0] tx_count
    );
        logic [31:0] word;
        word                                 = '0;
        word[STAT_TX_FULL]                   = tx_full;
        word[STAT_TX_EMPTY]                  = tx_empty;
        word[STAT_RX_FULL]                   = rx_full;
        word[STAT_RX_OVERRUN]                = rx_overrun;
        word[STAT_TX_OVERFLOW]               = tx_overflow;
        word[STAT_TX_COUNT_LSB +: 8]         = tx_count;
        return word;
    endfunction

endpackage : cpu_mmio_console_pkg
`default_nettype wire

// File: rtl/mmio_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmio_sync_fifo
// Description : Single-clock circular-buffer FIFO.
//               The caller must not push while full or pop while empty.
//               The drop-on-full policy belongs to the parent.
// Ports       : clk, rst (async, active-high)
//               push / push_data  - write one entry
//               pop               - retire the head entry
//               head              - entry at rd_ptr (don't-care when empty)
//               full, empty, count (AW+1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q,  count_d;

    // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == C_FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule : mmio_sync_fifo
`default_nettype wire

// File: rtl/cpu_mmio_console.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mmio_console
// Description : Memory-mapped console on the CPU data port.
//               Register map (offset = data_addr[3:2]):
//                 0 TXDATA - push a byte to the TX FIFO
//                 1 STATUS - flags and tx_count; write-1-to-clear error flags
//                 2 RXDATA - held RX byte; write bit0=1 to pop it
//                 3 CYCLE  - free-running counter, writable per byte lane
// Ports       : clk, rst (async, active-high)
//               sel, data_addr, data_wdata, data_wenable -> data_rdata
//                 (data_rdata is combinational)
//               tx_valid/tx_ready/tx_data   - TX byte sink handshake
//               rx_valid/rx_ready/rx_data   - RX byte source handshake
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mmio_console
    import cpu_mmio_console_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int TX_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wenable,
    output logic [31:0] data_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data
);

    // Only data_addr[3:2] is decoded. The outer decoder handles the rest.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, data_addr[31:4], data_addr[1:0]};

    mmio_reg_e w_reg;
    logic      w_bus_wr;
    logic      w_tx_push_req, w_tx_push, w_tx_pop;
    logic      w_tx_full, w_tx_empty;
    logic [TX_AW:0] w_tx_count;
    logic      w_status_wr, w_rx_pop, w_rx_capture;

    logic        tx_overflow_q, tx_overflow_d;
    logic        rx_overrun_q,  rx_overrun_d;
    logic        rx_full_q,     rx_full_d;
    logic [7:0]  rx_byte_q,     rx_byte_d;
    logic [31:0] cycle_q,       cycle_d;

    assign w_reg    = mmio_reg_e'(data_addr[3:2]);
    assign w_bus_wr = sel && (data_wenable != 4'b0000);

    // TX push. Fullness uses the pre-edge count, so a push while full is
    // dropped even if the sink pops in the same cycle.
    assign w_tx_push_req = w_bus_wr && (w_reg == MMIO_TXDATA) && data_wenable[0];
    assign w_tx_push     = w_tx_push_req && !w_tx_full;
    assign tx_valid      = !w_tx_empty;
    assign w_tx_pop      = tx_valid && tx_ready;

    mmio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH),
        .AW    (TX_AW)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (data_wdata[7:0]),
        .pop       (w_tx_pop),
        .head      (tx_data),
        .full      (w_tx_full),
        .empty     (w_tx_empty),
        .count     (w_tx_count)
    );

    assign w_status_wr  = w_bus_wr && (w_reg == MMIO_STATUS) && data_wenable[0];
    assign w_rx_pop     = w_bus_wr && (w_reg == MMIO_RXDATA) && data_wenable[0]
                          && data_wdata[0];
    // A capture needs rx_ready, which is low while full. So a pop of a full
    // register never coincides with a capture. The new byte lands next cycle.
    assign w_rx_capture = rx_valid && !rx_full_q;
    assign rx_ready     = !rx_full_q;

    always_comb begin
        tx_overflow_d = tx_overflow_q;
        rx_overrun_d  = rx_overrun_q;
        rx_full_d     = rx_full_q;
        rx_byte_d     = rx_byte_q;
        cycle_d       = cycle_q + 32'd1;

        // Clears are applied first, so a new event in the same cycle wins.
        if (w_status_wr && data_wdata[STAT_TX_OVERFLOW]) tx_overflow_d = 1'b0;
        if (w_status_wr && data_wdata[STAT_RX_OVERRUN])  rx_overrun_d  = 1'b0;
        if (w_tx_push_req && w_tx_full)                  tx_overflow_d = 1'b1;
        if (rx_valid && rx_full_q && !w_rx_pop)          rx_overrun_d  = 1'b1;

        if (w_rx_pop) rx_full_d = 1'b0;
        if (w_rx_capture) begin
            rx_full_d = 1'b1;
            rx_byte_d = rx_data;
        end

        // Written lanes replace the incremented value. Other lanes keep
        // counter+1.
        if (w_bus_wr && (w_reg == MMIO_CYCLE)) begin
            for (int i = 0; i < 4; i++) begin
                if (data_wenable[i]) cycle_d[8*i +: 8] = data_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_overflow_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            rx_full_q     <= 1'b0;
            rx_byte_q     <= 8'h00;
            cycle_q       <= 32'h0;
        end else begin
            tx_overflow_q <= tx_overflow_d;
            rx_overrun_q  <= rx_overrun_d;
            rx_full_q     <= rx_full_d;
            rx_byte_q     <= rx_byte_d;
            cycle_q       <= cycle_d;
        end
    end

    // Read data is returned only for a read (sel with no lanes enabled).
    always_comb begin
        data_rdata = 32'h0;
        if (sel && (data_wenable == 4'b0000)) begin
            case (w_reg)
                MMIO_STATUS: data_rdata = build_status(w_tx_full, w_tx_empty,
                                                       rx_full_q, rx_overrun_q,
                                                       tx_overflow_q,
                                                       8'(w_tx_count));
                MMIO_RXDATA: data_rdata = {23'b0, rx_full_q, rx_byte_q};
                MMIO_CYCLE:  data_rdata = cycle_q;
                default:     data_rdata = 32'h0;
            endcase
        end
    end

endmodule : cpu_mmio_console
`default_nettype wire
